// File: rtl/clock_gen.sv
// Behavioural free-running clock source for unit testbenches (simulation only).
// Optional period self-checker is enabled by defining CLOCK_GEN_CHECK_EN.
`timescale 1ns/1ps
module clock_gen #(
    parameter real tickRate  = 10.0,
    parameter bit  initLevel = 1'b0
) (
    output logic        clk,
    input  logic        rst,
    output logic [31:0] cycleCount
);

    logic        rst_on;
    int unsigned epoch;

    // X or Z on rst counts as deasserted.
    assign rst_on = (rst === 1'b1);

    // Each reset release launches a fresh toggle thread tagged with the current
    // epoch. Bumping the epoch on reset retires any thread still in flight,
    // which is how a pending toggle gets cancelled.
    task automatic run_phase();
        fork
            begin
                int unsigned my_epoch;
                bit          alive;
                my_epoch = epoch;
                alive    = 1'b1;
                while (alive) begin
                    #(tickRate);
                    // Step past the active region so a reset landing on the
                    // same timestep as a toggle is seen first and wins.
                    #0;
                    if (my_epoch != epoch || rst_on) begin
                        alive = 1'b0;
                    end else begin
                        clk = ~clk;
                        if (clk) begin
                            cycleCount = cycleCount + 32'd1;
                        end
                    end
                end
            end
        join_none
    endtask

    initial begin : generator
        epoch      = 0;
        clk        = 1'b0;
        cycleCount = '0;
        if (tickRate <= 0.0) begin
            $fatal(1, "clock_gen: tickRate must be positive, got %f", tickRate);
        end
        if (!rst_on) begin
            clk = initLevel;
            run_phase();
        end
        forever begin
            @(rst_on);
            if (rst_on) begin
                epoch      = epoch + 1;
                clk        = 1'b0;
                cycleCount = '0;
            end else begin
                run_phase();
            end
        end
    end

`ifdef CLOCK_GEN_CHECK_EN
    // Measures the spacing of consecutive rising edges; a reset breaks the chain.
    realtime     last_rise;
    bit          have_last;
    int unsigned chk_edges;
    int unsigned chk_errors;

    initial begin : period_checker
        realtime period;
        last_rise  = 0.0;
        have_last  = 1'b0;
        chk_edges  = 0;
        chk_errors = 0;
        forever begin
            @(posedge clk or posedge rst_on);
            if (rst_on) begin
                have_last = 1'b0;
            end else if (clk) begin
                chk_edges = chk_edges + 1;
                if (have_last) begin
                    period = $realtime - last_rise;
                    if (period - 2.0 * tickRate > 0.0010001 ||
                        2.0 * tickRate - period > 0.0010001) begin
                        chk_errors = chk_errors + 1;
                        $error("clock_gen: bad period at %0t: measured %0.3f ns, wanted %0.3f ns",
                               $realtime, period, 2.0 * tickRate);
                    end
                end
                last_rise = $realtime;
                have_last = 1'b1;
            end
        end
    end

    final begin
        $display("clock_gen checker: %0d rising edges, %0d period errors", chk_edges, chk_errors);
    end
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: a time-based reference model (edge count
// derived from elapsed time since the last phase origin) plus literal spot checks.
`timescale 1ns/1ps
module tb_clock_gen;

    logic        clk_a;
    logic        clk_b;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;

    clock_gen #(.tickRate(10.0)) dut (
        .clk        (clk_a),
        .rst        (rst_a),
        .cycleCount (cnt_a)
    );

    clock_gen #(.tickRate(2.5)) dut_b (
        .clk        (clk_b),
        .rst        (rst_b),
        .cycleCount (cnt_b)
    );

    int     vectors;
    int     miscompares;
    bit     model_on;
    bit     model_rst;
    longint model_origin_ps;
    bit     done;
    longint rise_a[$];
    longint rise_b[$];

    function automatic longint now_ps();
        return longint'($realtime * 1000.0);
    endfunction

    // Reference: half-periods elapsed since the phase origin give the level
    // (odd count = high) and the number of completed rising edges.
    function automatic void model(input longint t_ps, input longint origin_ps,
                                  input longint tick_ps, input bit in_rst,
                                  output bit e_clk, output logic [31:0] e_cnt);
        longint halves;
        if (in_rst) begin
            e_clk = 1'b0;
            e_cnt = '0;
        end else begin
            halves = (t_ps - origin_ps) / tick_ps;
            e_clk  = (halves % 2) == 1;
            e_cnt  = 32'((halves + 1) / 2);
        end
    endfunction

    task automatic check(input string name, input longint actual, input longint expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t ps",
                     name, actual, actual, expected, expected, now_ps());
        end
    endtask

    task automatic at(input real t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic set_rst(input bit v);
        rst_a     = v;
        model_rst = v;
        if (!v) model_origin_ps = now_ps();
    endtask

    always @(posedge clk_a) rise_a.push_back(now_ps());
    always @(posedge clk_b) rise_b.push_back(now_ps());

    // Continuous comparison at quarter-ns offsets, clear of every edge.
    initial begin : compare
        bit          ec;
        logic [31:0] en;
        #0.25;
        while (!done) begin
            if (model_on) begin
                model(now_ps(), model_origin_ps, 10000, model_rst, ec, en);
                check("model_clk_a", longint'(clk_a), longint'(ec));
                check("model_cnt_a", longint'(cnt_a), longint'(en));
            end
            model(now_ps(), 0, 2500, 1'b0, ec, en);
            check("model_clk_b", longint'(clk_b), longint'(ec));
            check("model_cnt_b", longint'(cnt_b), longint'(en));
            #1;
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded 50000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int     n_before;
        real    t0;
        vectors         = 0;
        miscompares     = 0;
        done            = 1'b0;
        model_on        = 1'b1;
        model_rst       = 1'b0;
        model_origin_ps = 0;
        rst_a           = 1'b0;
        rst_b           = 1'b0;

        at(0.25);
        check("init_clk", longint'(clk_a), 0);
        check("init_cnt", longint'(cnt_a), 0);

        at(50.25);
        check("b_cnt_50ns", longint'(cnt_b), 10);
        if (rise_b.size() >= 3) begin
            check("b_rise0", rise_b[0], 2500);
            check("b_rise1", rise_b[1], 7500);
            check("b_rise2", rise_b[2], 12500);
            check("b_period", rise_b[1] - rise_b[0], 5000);
        end else begin
            check("b_rise_count", longint'(rise_b.size()), 3);
        end

        at(95.25);
        check("clk_95ns", longint'(clk_a), 1);
        at(100.25);
        check("cnt_100ns", longint'(cnt_a), 5);
        check("rises_100ns", longint'(rise_a.size()), 5);
        for (int i = 0; i < 5 && i < rise_a.size(); i++) begin
            check($sformatf("rise_%0d", i), rise_a[i], 10000 + 20000 * i);
        end

        // Reset while clk is high, release mid-phase.
        at(135.0);
        set_rst(1'b1);
        at(135.25);
        check("rst_clk_low", longint'(clk_a), 0);
        check("rst_cnt_zero", longint'(cnt_a), 0);
        n_before = rise_a.size();
        check("rises_before_rst", longint'(n_before), 7);
        at(152.0);
        set_rst(1'b0);
        at(162.25);
        check("post_rel_cnt", longint'(cnt_a), 1);
        check("post_rel_clk", longint'(clk_a), 1);
        at(185.0);
        check("post_rel_rises", longint'(rise_a.size()), longint'(n_before + 2));
        if (rise_a.size() >= n_before + 2) begin
            check("post_rel_rise0", rise_a[n_before], 162000);
            check("post_rel_rise1", rise_a[n_before + 1], 182000);
        end

        // Reset lands exactly on a scheduled rising edge.
        at(202.0);
        set_rst(1'b1);
        at(202.25);
        check("edge_rst_clk", longint'(clk_a), 0);
        check("edge_rst_cnt", longint'(cnt_a), 0);
        at(214.25);
        check("edge_rst_hold_cnt", longint'(cnt_a), 0);
        check("no_rise_at_202", longint'(rise_a.size()), longint'(n_before + 2));
        at(215.0);
        set_rst(1'b0);
        at(225.25);
        check("edge_rel_cnt", longint'(cnt_a), 1);

        // Random reset pulses, including glitches shorter than tickRate.
        at(230.0);
        for (int i = 0; i < 30; i++) begin
            #($urandom_range(60, 1));
            set_rst(1'b1);
            #($urandom_range(25, 1));
            set_rst(1'b0);
        end

        // Counter wrap via hierarchical deposit.
        #5;
        set_rst(1'b1);
        #3;
        set_rst(1'b0);
        t0 = $realtime;
        at(t0 + 5.0);
        model_on = 1'b0;
        dut.cycleCount = 32'hFFFF_FFFF;
        at(t0 + 5.25);
        check("deposit_cnt", longint'(cnt_a), 64'h0000_0000_FFFF_FFFF);
        at(t0 + 10.25);
        check("wrap_cnt", longint'(cnt_a), 0);
        check("wrap_clk", longint'(clk_a), 1);

        #5;
        done = 1'b1;
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Behavioural, simulation-only free-running clock source for unit testbenches.
- Produces a 50% duty-cycle square wave on `clk`; `tickRate` sets the half-period in ns.
- Asynchronous active-high `rst` forces the clock low and restarts its phase.
- Provides a rising-edge counter so benches can time stimulus and assert clock activity. Not synthesizable.

Parameters:
- tickRate, 10, half-period of `clk` in ns; real values allowed down to 0.001 (1 ps resolution); full period = 2*tickRate.
- initLevel, 0, level driven on `clk` at time 0 and while reset is active is always 0; initLevel applies only at time 0 when `rst` is not asserted.

Ports:
- clk  output  1  generated clock; must be the first port so a one-port positional instantiation binds it.
- rst  input  1  asynchronous reset, active-high; unconnected or X/Z counts as deasserted.
- cycleCount  output  32  number of `clk` rising edges since time 0 or since the last reset release.

Behaviour:
- Module carries timescale 1ns/1ps; all delays are in ns.
- Time 0, `rst` not 1: `clk` = initLevel, `cycleCount` = 0.
- Free run: `clk` toggles every tickRate ns, giving high time = low time = tickRate.
- With initLevel=0 and tickRate=10: rising edges at 10, 30, 50, 70, 90 ns; falling edges at 20, 40, 60, 80 ns.
- `cycleCount` increments by 1 in the same timestep as each `clk` 0->1 transition, after `clk` updates.
- `cycleCount` wraps from 0xFFFFFFFF to 0 silently.
- Reset is asynchronous. On `rst` becoming 1 (compared with `=== 1'b1`), in the same timestep:
  - `clk` goes to 0 and any pending toggle is cancelled;
  - `cycleCount` goes to 0.
- While `rst` = 1: `clk` holds 0 and `cycleCount` holds 0.
- On `rst` falling to 0/X/Z at time T: `clk` stays 0 until T+tickRate, then rises (`cycleCount` becomes 1), then continues the normal toggle cadence. The reset is phase-restarting.
- Reset asserted exactly at a scheduled toggle time: reset wins; no edge and no count occurs.
- Glitch on `rst` shorter than tickRate: still restarts the phase. There is no minimum pulse width.
- `clk` never takes X or Z after time 0.
- Parameter check at time 0: if tickRate <= 0, `$fatal` with a message and produce no clock.

Optional Feature:
- Macro: CLOCK_GEN_CHECK_EN.
- Defined: adds an internal self-checker that compares the interval between consecutive rising edges against 2*tickRate.
  - Intervals broken by a reset are excluded.
  - A mismatch greater than 1 ps gives `$error` with the sim time and measured period.
  - At `$finish`, a `$display` summary prints the edge count and error count.
- Undefined: no checker logic, no messages. Port and clock behaviour are identical in both cases.

Test Plan:
- Default params, `rst` unconnected, run 100 ns: rising edges at 10/30/50/70/90 ns; `clk` = 1 at 95 ns; `cycleCount` = 5 at 100 ns.
- tickRate=2.5: rising edges at 2.5, 7.5, 12.5 ns; measured period 5.000 ns; `cycleCount` = 10 at 50 ns.
- Assert `rst` at 35 ns (`clk` high), release at 52 ns:
  - `clk` = 0 at 35 ns and `cycleCount` = 0 at 35 ns;
  - next rise at 62 ns with `cycleCount` = 1;
  - following rise at 82 ns.
- Assert `rst` exactly at 50 ns: no rise at 50 ns; `cycleCount` stays 0 while `rst` = 1.
- Build with CLOCK_GEN_CHECK_EN, tickRate=10, run 200 ns with one reset pulse: zero `$error` messages; summary reports the correct edge count.
- Force `cycleCount` to 0xFFFFFFFF via hierarchical deposit, then one rising edge: `cycleCount` = 0.
